// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus channel: one request phase (req/addr_ok) and one
// response phase (data_ok/rdata). The same interface describes the two
// CPU-side requesters and the single memory-side port.
//   master modport : the side that issues requests
//   slave  modport : the side that accepts requests and returns responses
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Two-requester to one-port arbiter for the SRAM-like bus.
// The instruction fetch side (i_bus) and the load/store side (d_bus) share
// one memory port (m_bus). One request is accepted in IDLE, latched, issued
// on the memory port and its response is routed back to the owner. Only one
// transaction is ever outstanding.
//
// Build option:
//   ARB_RR_EN  - when defined, simultaneous requests are granted round-robin
//                using last_grant (reset value I, so D wins the first tie).
//                When undefined, D always has priority over I.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  sram_like_arbiter_if.slave  i_bus,
  sram_like_arbiter_if.slave  d_bus,
  sram_like_arbiter_if.master m_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Architectural state
  state_e            state_q;
  logic              owner_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              m_req_q;
  // High during reset and for the first cycle after it, so no request is
  // acknowledged before the slave side has also left reset.
  logic              rst_dly_q;
`ifdef ARB_RR_EN
  logic              last_grant_q;
`endif

  // Arbitration and request selection
  logic              grant_d;
  logic              grant_i;
  logic              accept_en;
  logic              take_req;
  logic              resp_en;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick which requester wins this cycle (only meaningful in IDLE).
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
`ifdef ARB_RR_EN
    if (d_bus.req && i_bus.req) begin
      // Tie: give the port to whoever did not get it last time.
      grant_d = (last_grant_q == OWNER_I);
      grant_i = (last_grant_q == OWNER_D);
    end else begin
      grant_d = d_bus.req;
      grant_i = i_bus.req;
    end
`else
    if (d_bus.req) begin
      grant_d = 1'b1;
      grant_i = 1'b0;
    end else begin
      grant_d = 1'b0;
      grant_i = i_bus.req;
    end
`endif
  end

  // Mux the winning requester's fields for latching.
  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = 2'd0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (grant_d) begin
      sel_wr    = d_bus.wr;
      sel_size  = d_bus.size;
      sel_addr  = d_bus.addr;
      sel_wdata = d_bus.wdata;
    end else begin
      sel_wr    = i_bus.wr;
      sel_size  = i_bus.size;
      sel_addr  = i_bus.addr;
      sel_wdata = i_bus.wdata;
    end
  end

  // Accept is only possible in IDLE and outside the reset window.
  assign accept_en = (state_q == ST_IDLE) & ~reset & ~rst_dly_q;
  assign take_req  = accept_en & (grant_d | grant_i);

  // A response is only honoured while waiting for it; stray data_ok elsewhere
  // is dropped.
  assign resp_en   = (state_q == ST_WAIT) & m_bus.data_ok & ~reset;

  // Requester-side handshakes
  assign d_bus.addr_ok = accept_en & grant_d;
  assign i_bus.addr_ok = accept_en & grant_i;
  assign d_bus.data_ok = resp_en & (owner_q == OWNER_D);
  assign i_bus.data_ok = resp_en & (owner_q == OWNER_I);

  // Read data is broadcast; the consumer qualifies it with its data_ok.
  assign d_bus.rdata   = m_bus.rdata;
  assign i_bus.rdata   = m_bus.rdata;

  // Memory-side request straight from registers, stable while stalled.
  assign m_bus.req     = m_req_q;
  assign m_bus.wr      = wr_q;
  assign m_bus.size    = size_q;
  assign m_bus.addr    = addr_q;
  assign m_bus.wdata   = wdata_q;

  // Transaction FSM: latch in IDLE, present in ISSUE, await response in WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_I;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      m_req_q      <= 1'b0;
      rst_dly_q    <= 1'b1;
`ifdef ARB_RR_EN
      last_grant_q <= OWNER_I;
`endif
    end else begin
      rst_dly_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take_req) begin
            owner_q      <= grant_d ? OWNER_D : OWNER_I;
            wr_q         <= sel_wr;
            size_q       <= sel_size;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            m_req_q      <= 1'b1;
            state_q      <= ST_ISSUE;
`ifdef ARB_RR_EN
            last_grant_q <= grant_d ? OWNER_D : OWNER_I;
`endif
          end
        end
        ST_ISSUE: begin
          // Hold the latched request until the slave takes it.
          if (m_bus.addr_ok) begin
            m_req_q <= 1'b0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_bus.data_ok) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          m_req_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter. Inputs change 1 time
// unit after the rising edge, outputs are sampled 1 time unit later.
// Expected grant order follows ARB_RR_EN when the bench is built with it.
module tb_sram_like_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) i_bus ();
  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) d_bus ();
  sram_like_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_bus ();

  sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .i_bus (i_bus),
    .d_bus (d_bus),
    .m_bus (m_bus)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  logic tb_last_grant = 1'b0;   // 0 = I, 1 = D

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction. The caller has already set up the requests
  // for the current (IDLE) cycle.
  task automatic txn(input string tag, input logic exp_d,
                     input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                     input logic exp_wr, input logic [1:0] exp_size,
                     input int stall, input logic spur, input logic poke_other,
                     input logic [31:0] rdata);
    #1;
    check($sformatf("%s.accept_d_addr_ok", tag), d_bus.addr_ok, exp_d);
    check($sformatf("%s.accept_i_addr_ok", tag), i_bus.addr_ok, !exp_d);
    check($sformatf("%s.accept_m_req", tag), m_bus.req, 1'b0);
    next_cycle();
    // Drop and scramble the owner's request; it must not matter any more.
    if (exp_d) begin
      d_bus.req = 1'b0; d_bus.addr = 32'hFFFF_FFFF; d_bus.wdata = 32'hFFFF_FFFF; d_bus.wr = ~d_bus.wr;
      if (poke_other) i_bus.req = 1'b1;
    end else begin
      i_bus.req = 1'b0; i_bus.addr = 32'hFFFF_FFFF; i_bus.wdata = 32'hFFFF_FFFF; i_bus.wr = ~i_bus.wr;
      if (poke_other) d_bus.req = 1'b1;
    end
    tb_last_grant = exp_d;
    for (int k = 0; k <= stall; k++) begin
      m_bus.addr_ok = (k == stall);
      m_bus.data_ok = spur;
      m_bus.rdata   = 32'h0BAD_0BAD;
      #1;
      check($sformatf("%s.issue%0d_m_req", tag, k), m_bus.req, 1'b1);
      check($sformatf("%s.issue%0d_m_addr", tag, k), m_bus.addr, exp_addr);
      check($sformatf("%s.issue%0d_m_wdata", tag, k), m_bus.wdata, exp_wdata);
      check($sformatf("%s.issue%0d_m_wr", tag, k), m_bus.wr, exp_wr);
      check($sformatf("%s.issue%0d_m_size", tag, k), m_bus.size, exp_size);
      check($sformatf("%s.issue%0d_addr_ok", tag, k), {i_bus.addr_ok, d_bus.addr_ok}, 2'b00);
      check($sformatf("%s.issue%0d_data_ok", tag, k), {i_bus.data_ok, d_bus.data_ok}, 2'b00);
      next_cycle();
    end
    m_bus.addr_ok = 1'b0;
    m_bus.data_ok = 1'b1;
    m_bus.rdata   = rdata;
    #1;
    check($sformatf("%s.wait_m_req", tag), m_bus.req, 1'b0);
    check($sformatf("%s.wait_d_data_ok", tag), d_bus.data_ok, exp_d);
    check($sformatf("%s.wait_i_data_ok", tag), i_bus.data_ok, !exp_d);
    check($sformatf("%s.wait_rdata", tag), exp_d ? d_bus.rdata : i_bus.rdata, rdata);
    check($sformatf("%s.wait_addr_ok", tag), {i_bus.addr_ok, d_bus.addr_ok}, 2'b00);
    next_cycle();
    m_bus.data_ok = 1'b0;
  endtask

  task automatic set_i(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    i_bus.req = req; i_bus.wr = wr; i_bus.size = 2'd2; i_bus.addr = addr; i_bus.wdata = wdata;
  endtask

  task automatic set_d(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    d_bus.req = req; d_bus.wr = wr; d_bus.size = 2'd2; d_bus.addr = addr; d_bus.wdata = wdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    logic exp_d;
    reset = 1'b1;
    set_i(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b1, 1'b0, 32'h0, 32'h0);
    m_bus.addr_ok = 1'b0; m_bus.data_ok = 1'b0; m_bus.rdata = 32'h0;

    // Reset state, with a pending D request that must not be acknowledged.
    next_cycle();
    #1;
    check("rst.m_req", m_bus.req, 1'b0);
    check("rst.d_addr_ok", d_bus.addr_ok, 1'b0);
    check("rst.m_addr", m_bus.addr, 32'h0);
    check("rst.m_wdata", m_bus.wdata, 32'h0);
    check("rst.m_wr_size", {m_bus.wr, m_bus.size}, 3'b000);
    next_cycle();
    reset = 1'b0;
    #1;
    check("rst_after.d_addr_ok", d_bus.addr_ok, 1'b0);
    check("rst_after.m_req", m_bus.req, 1'b0);
    next_cycle();
    d_bus.req = 1'b0;
    #1;
    check("rst_after2.m_req", m_bus.req, 1'b0);
    next_cycle();

    // Tie from reset: D first, then the waiting I.
    set_i(1'b1, 1'b0, 32'hBFC0_0000, 32'h0);
    set_d(1'b1, 1'b0, 32'h8000_0010, 32'h0);
    txn("tie_d", 1'b1, 32'h8000_0010, 32'h0, 1'b0, 2'd2, 0, 1'b0, 1'b0, 32'hAAAA_0001);
    txn("tie_i", 1'b0, 32'hBFC0_0000, 32'h0, 1'b0, 2'd2, 0, 1'b0, 1'b0, 32'hAAAA_0002);

    // Four back-to-back ties.
    for (int t = 0; t < 4; t++) begin
      set_i(1'b1, 1'b0, 32'hBFC0_0100, 32'h1111_0000);
      set_d(1'b1, 1'b0, 32'h8000_0200, 32'h2222_0000);
`ifdef ARB_RR_EN
      exp_d = (tb_last_grant == 1'b0);
`else
      exp_d = 1'b1;
`endif
      txn($sformatf("tie4_%0d", t), exp_d, exp_d ? 32'h8000_0200 : 32'hBFC0_0100,
          exp_d ? 32'h2222_0000 : 32'h1111_0000, 1'b0, 2'd2, 0, 1'b0, 1'b0, 32'h5555_0000 + t);
    end
    set_i(1'b0, 1'b0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 32'h0, 32'h0);

    // D read alone.
    set_d(1'b1, 1'b0, 32'h1000_0004, 32'h0);
    txn("d_read", 1'b1, 32'h1000_0004, 32'h0, 1'b0, 2'd2, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);

    // D word write with a 5-cycle slave stall, spurious data_ok in ISSUE
    // and I requesting during the stall.
    set_d(1'b1, 1'b1, 32'h2000_0008, 32'h1234_5678);
    txn("d_write_stall", 1'b1, 32'h2000_0008, 32'h1234_5678, 1'b1, 2'd2, 5, 1'b1, 1'b1, 32'h0);
    set_i(1'b0, 1'b0, 32'h0, 32'h0);

    // Spurious data_ok in IDLE: dropped, state unchanged.
    m_bus.data_ok = 1'b1;
    #1;
    check("spur_idle.data_ok", {i_bus.data_ok, d_bus.data_ok}, 2'b00);
    check("spur_idle.m_req", m_bus.req, 1'b0);
    next_cycle();
    m_bus.data_ok = 1'b0;
    set_i(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    i_bus.size = 2'd1;
    txn("i_half", 1'b0, 32'h0000_0040, 32'h0, 1'b0, 2'd1, 0, 1'b0, 1'b0, 32'hCAFE_F00D);

    // Reset while waiting for the response.
    set_i(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    #1;
    check("rstw.accept_i_addr_ok", i_bus.addr_ok, 1'b1);
    next_cycle();
    i_bus.req = 1'b0;
    m_bus.addr_ok = 1'b1;
    #1;
    check("rstw.issue_m_req", m_bus.req, 1'b1);
    next_cycle();
    m_bus.addr_ok = 1'b0;
    m_bus.data_ok = 1'b1;
    reset = 1'b1;
    #1;
    check("rstw.in_reset_data_ok", {i_bus.data_ok, d_bus.data_ok}, 2'b00);
    check("rstw.in_reset_m_req", m_bus.req, 1'b0);
    next_cycle();
    reset = 1'b0;
    tb_last_grant = 1'b0;
    i_bus.req = 1'b1;
    #1;
    check("rstw.after_data_ok", {i_bus.data_ok, d_bus.data_ok}, 2'b00);
    check("rstw.after_i_addr_ok", i_bus.addr_ok, 1'b0);
    check("rstw.after_m_req", m_bus.req, 1'b0);
    next_cycle();
    m_bus.data_ok = 1'b0;
    set_i(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    txn("post_rst_i", 1'b0, 32'h0000_0200, 32'h0, 1'b0, 2'd2, 0, 1'b0, 1'b0, 32'h7777_8888);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Two-master to one-slave arbiter for the SRAM-like bus.
- Shares a single memory port between the instruction fetch requester (I) and the load/store requester (D).
- Accepts one master request, latches it, issues it to the slave and routes the response back to the owner.
- Exactly one transaction is outstanding at any time; sits between the CPU core and the memory/bridge interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  I request valid.
- i_wr  in  1  I write (1) / read (0).
- i_size  in  2  I access size: 0=byte, 1=half, 2=word.
- i_addr  in  ADDR_W  I address.
- i_wdata  in  DATA_W  I write data.
- i_addr_ok  out  1  I request accepted this cycle.
- i_data_ok  out  1  I response valid this cycle.
- i_rdata  out  DATA_W  I read data.
- d_req, d_wr, d_size, d_addr, d_wdata  in  same as I  D request fields.
- d_addr_ok, d_data_ok, d_rdata  out  same as I  D handshake and response.
- m_req  out  1  slave request valid.
- m_wr  out  1  slave write flag.
- m_size  out  2  slave access size.
- m_addr  out  ADDR_W  slave address.
- m_wdata  out  DATA_W  slave write data.
- m_addr_ok  in  1  slave accepted request.
- m_data_ok  in  1  slave response valid.
- m_rdata  in  DATA_W  slave read data.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- States: IDLE, ISSUE, WAIT. Registers: state, owner (0=I, 1=D), latched wr/size/addr/wdata, last_grant.
- Reset values: state=IDLE, owner=0, last_grant=0, latched fields=0.
- Output values during reset and the cycle after: m_req=0, all *_addr_ok=0, all *_data_ok=0.

IDLE:
- *_addr_ok is combinational: high only when state==IDLE, reset==0, and that master is granted.
- Grant, fixed priority: D over I.
- A granted request is latched at the clock edge; owner is set; next state is ISSUE.
- The master sees addr_ok in the same cycle as its req; the request counts as taken.
- No req from either master: stay in IDLE.

ISSUE:
- m_req=1; m_wr, m_size, m_addr, m_wdata are driven from the latched registers and held stable.
- m_addr_ok=1: next state is WAIT.
- m_addr_ok=0: remain in ISSUE; the latched request is not altered.
- m_data_ok is ignored in this state.

WAIT:
- m_req=0.
- On m_data_ok=1: the owner's *_data_ok=1 for that cycle (combinational), *_rdata=m_rdata, next state is IDLE.
- The non-owner's data_ok stays 0.

Rates and latency:
- Minimum latency, request to data_ok: 3 cycles (accept, issue with immediate addr_ok, one-cycle slave response).
- Throughput: one transaction per at most 3 cycles; no new accept while in ISSUE or WAIT.
- *_rdata equals m_rdata in every cycle; consumers qualify it with data_ok.

Boundary conditions:
- Writes still produce a data_ok (write acknowledge), routed to the owner.
- m_data_ok outside WAIT is dropped.
- Master req deasserted after acceptance has no effect on the transaction.
- Reset asserted in ISSUE or WAIT: return to IDLE and abandon the transaction. The slave is required to be reset in the same cycle.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous I and D requests in IDLE, grant the master not equal to last_grant. last_grant updates on every accept; reset value 0 (I), so D wins the first tie.
- A lone requester is always granted.
- Undefined: fixed D priority; last_grant is not implemented.

Test Plan:
- D read alone: d_req=1, d_addr=0x1000_0004, slave addr_ok immediate, data_ok next cycle with m_rdata=0xDEADBEEF -> d_addr_ok at cycle 0, m_req with m_addr=0x1000_0004 at cycle 1, d_data_ok and d_rdata=0xDEADBEEF at cycle 2, i_data_ok=0 throughout.
- Both requesting in IDLE, i_addr=0xBFC0_0000, d_addr=0x8000_0010 -> D granted first (m_addr=0x8000_0010), I granted in the IDLE after D's data_ok. With ARB_RR_EN, four consecutive ties alternate D, I, D, I.
- Slave stall: m_addr_ok held 0 for 5 cycles -> m_req held with constant m_addr/m_wdata, no new addr_ok to either master; on addr_ok, proceeds to WAIT.
- Write, d_wr=1, d_size=2, d_wdata=0x1234_5678 -> m_wr=1, m_size=2, m_wdata=0x1234_5678; write ack routed as d_data_ok.
- Spurious m_data_ok in IDLE and ISSUE -> no *_data_ok pulse, no state change.
- Reset asserted in WAIT -> next cycle IDLE, m_req=0, no data_ok. A new i_req is then accepted normally.
